// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle of everything between the multicycle sequencer and the datapath /
// memory side of the 16-bit RISC core.
//   master : the sequencer (samples Ins/Mem_ready/PSW_NZC/Go, drives controls)
//   slave  : datapath / memory / testbench side
// Inputs to the sequencer : Ins, Mem_ready, PSW_NZC {N,Z,C}, Go
// Outputs of the sequencer: IR, Step, memory strobes, PC/ALU/PSW/RF controls,
//                           Out_valid, Done, Halted, Illegal, Fault
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if #(
    parameter int INS_W = 16,
    parameter int CNT_W = 3
);
    logic [INS_W-1:0] Ins;
    logic             Mem_ready;
    logic [2:0]       PSW_NZC;
    logic             Go;

    logic [INS_W-1:0] IR;
    logic [CNT_W-1:0] Step;
    logic             Mem_re;
    logic             Mem_we;
    logic             IR_load;
    logic             PC_load;
    logic [1:0]       PC_sel;
    logic [1:0]       ALU_op;
    logic             ALU_src_imm;
    logic             PSW_we;
    logic             RF_we;
    logic [1:0]       WB_sel;
    logic             Out_valid;
    logic             Done;
    logic             Halted;
    logic             Illegal;
    logic             Fault;

    modport master (
        input  Ins, Mem_ready, PSW_NZC, Go,
        output IR, Step, Mem_re, Mem_we, IR_load, PC_load, PC_sel, ALU_op,
               ALU_src_imm, PSW_we, RF_we, WB_sel, Out_valid, Done, Halted,
               Illegal, Fault
    );

    modport slave (
        output Ins, Mem_ready, PSW_NZC, Go,
        input  IR, Step, Mem_re, Mem_we, IR_load, PC_load, PC_sel, ALU_op,
               ALU_src_imm, PSW_we, RF_we, WB_sel, Out_valid, Done, Halted,
               Illegal, Fault
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Sequencer for the multicycle 16-bit RISC core: FSM + instruction register +
// step counter. Fetches over a ready/wait memory handshake (with timeout into
// a sticky FAULT state), decodes the latched instruction and walks it through
// DECODE / EXEC / MEM / WB, plus HALT/resume and an illegal-opcode trap.
// Ports:
//   clk   : clock
//   Rst_n : synchronous active-low reset
//   bus   : multicycle_ctrl_if.master (see interface for signal list)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int INS_W    = 16,
    parameter int CNT_W    = 3,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              Rst_n,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    typedef enum logic [4:0] {
        C_ALU, C_CMP, C_ADDI, C_SUBI, C_LDRRI, C_LDRRR, C_STRRI, C_STRRR,
        C_LHI, C_LLI, C_MOV, C_BCC, C_BAL, C_JMP, C_JALRL, C_JALRR, C_JR,
        C_OUT, C_HLT, C_ILL
    } cls_t;

    localparam int               WCW      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int               WLIM     = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
    localparam logic [CNT_W-1:0] STEP_MAX = '1;

    state_t           r_state, w_next;
    logic [INS_W-1:0] r_ir;
    logic [CNT_W-1:0] r_step;
    logic [WCW-1:0]   r_wait;
    logic             r_halt_first;

    logic [4:0] w_opc;
    logic [2:0] w_cond;
    logic [1:0] w_funct;
    cls_t       w_cls;
    logic       w_taken;
    logic       w_timeout;
    logic       w_is_load;

    logic       w_mem_re, w_mem_we, w_ir_load, w_pc_load, w_alu_imm;
    logic       w_psw_we, w_rf_we, w_out_valid, w_done, w_halted, w_illegal;
    logic       w_fault;
    logic [1:0] w_pc_sel, w_alu_op, w_wb_sel;

    assign w_opc   = r_ir[INS_W-1 -: 5];
    assign w_cond  = r_ir[INS_W-6 -: 3];
    assign w_funct = r_ir[1:0];

    // Instruction class from the latched IR (valid from DECODE onwards)
    always_comb begin
        w_cls = C_ILL;
        case (w_opc)
            5'b00000: w_cls = C_ALU;
            5'b00001: w_cls = C_LHI;
            5'b00010: w_cls = C_LLI;
            5'b00011: w_cls = C_LDRRI;
            5'b00100: w_cls = (w_funct == 2'b00) ? C_LDRRR : C_ILL;
            5'b00101: w_cls = C_STRRI;
            5'b00110: w_cls = (w_funct == 2'b00) ? C_STRRR :
                              (w_funct == 2'b01) ? C_CMP   : C_ILL;
            5'b00111: w_cls = C_ADDI;
            5'b01000: w_cls = C_SUBI;
            5'b01011: w_cls = C_MOV;
            5'b11000: w_cls = C_BCC;
            5'b11001: w_cls = C_BAL;
            5'b10000: w_cls = C_JMP;
            5'b10001: w_cls = C_JALRL;
            5'b10010: w_cls = C_JALRR;
            5'b10011: w_cls = C_JR;
            5'b11100: w_cls = (w_funct == 2'b00) ? C_OUT :
                              (w_funct == 2'b01) ? C_HLT : C_ILL;
            default:  w_cls = C_ILL;
        endcase
    end

    assign w_is_load = (w_cls == C_LDRRI) || (w_cls == C_LDRRR);

    // Branch condition on live flags {N,Z,C}; cond 111 is never taken
    always_comb begin
        w_taken = 1'b0;
        case (w_cond)
            3'b000:  w_taken = ~bus.PSW_NZC[1];
            3'b001:  w_taken =  bus.PSW_NZC[1];
            3'b010:  w_taken =  bus.PSW_NZC[0];
            3'b011:  w_taken = ~bus.PSW_NZC[0];
            3'b100:  w_taken =  bus.PSW_NZC[2];
            3'b101:  w_taken = ~bus.PSW_NZC[2];
            3'b110:  w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // r_wait counts the stalled cycles already spent in this FETCH/MEM visit;
    // the WAIT_MAX-th consecutive stall diverts to FAULT instead of retrying.
    assign w_timeout = (WAIT_MAX > 0) && (r_wait == WCW'(WLIM)) && !bus.Mem_ready;

    always_comb begin
        w_next      = r_state;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_sel    = 2'b00;
        w_alu_op    = 2'b00;
        w_alu_imm   = 1'b0;
        w_psw_we    = 1'b0;
        w_rf_we     = 1'b0;
        w_wb_sel    = 2'b00;
        w_out_valid = 1'b0;
        w_done      = 1'b0;
        w_halted    = 1'b0;
        w_illegal   = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_re = 1'b1;
                if (bus.Mem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                w_pc_load = 1'b1;
                case (w_cls)
                    C_LHI, C_LLI, C_MOV: w_next = S_WB;
                    C_HLT:               w_next = S_HALT;
                    C_ILL: begin
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                        w_next    = S_FETCH;
                    end
                    default:             w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_next = S_FETCH;
                case (w_cls)
                    C_ALU: begin
                        w_alu_op = w_funct;
                        w_psw_we = 1'b1;
                        w_next   = S_WB;
                    end
                    C_ADDI, C_SUBI: begin
                        w_alu_op  = (w_cls == C_SUBI) ? 2'b10 : 2'b00;
                        w_alu_imm = 1'b1;
                        w_psw_we  = 1'b1;
                        w_next    = S_WB;
                    end
                    C_CMP: begin
                        w_alu_op = 2'b10;
                        w_psw_we = 1'b1;
                        w_done   = 1'b1;
                    end
                    C_LDRRI, C_STRRI: begin
                        w_alu_imm = 1'b1;
                        w_next    = S_MEM;
                    end
                    C_LDRRR, C_STRRR: w_next = S_MEM;
                    C_BCC: begin
                        w_illegal = (w_cond == 3'b111);
                        w_pc_load = w_taken;
                        w_pc_sel  = w_taken ? 2'b01 : 2'b00;
                        w_done    = 1'b1;
                    end
                    C_BAL: begin
                        w_pc_load = 1'b1;
                        w_pc_sel  = 2'b01;
                        w_next    = S_WB;
                    end
                    C_JMP, C_JR: begin
                        w_pc_load = 1'b1;
                        w_pc_sel  = (w_cls == C_JMP) ? 2'b11 : 2'b10;
                        w_done    = 1'b1;
                    end
                    C_JALRL, C_JALRR: begin
                        w_pc_load = 1'b1;
                        w_pc_sel  = (w_cls == C_JALRL) ? 2'b11 : 2'b10;
                        w_next    = S_WB;
                    end
                    C_OUT: begin
                        w_out_valid = 1'b1;
                        w_done      = 1'b1;
                    end
                    default: w_done = 1'b1;
                endcase
            end
            S_MEM: begin
                w_mem_re = w_is_load;
                w_mem_we = !w_is_load;
                if (bus.Mem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_done = 1'b1;
                        w_next = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                w_rf_we = 1'b1;
                w_done  = 1'b1;
                w_next  = S_FETCH;
                case (w_cls)
                    C_LDRRI, C_LDRRR:         w_wb_sel = 2'b01;
                    C_LHI, C_LLI, C_MOV:      w_wb_sel = 2'b10;
                    C_BAL, C_JALRL, C_JALRR:  w_wb_sel = 2'b11;
                    default:                  w_wb_sel = 2'b00;
                endcase
            end
            S_HALT: begin
                w_halted = 1'b1;
                w_done   = r_halt_first;
                if (bus.Go) w_next = S_FETCH;
            end
            S_FAULT: w_fault = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            r_state      <= S_FETCH;
            r_ir         <= '0;
            r_step       <= '0;
            r_wait       <= '0;
            r_halt_first <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_halt_first <= (w_next == S_HALT) && (r_state != S_HALT);
            if (w_ir_load) r_ir <= bus.Ins;
            // Step restarts after Done and also on a Go resume (no Done there)
            if (w_done || (w_next == S_FETCH && r_state != S_FETCH))
                r_step <= '0;
            else if (r_step != STEP_MAX)
                r_step <= r_step + 1'b1;
            // Staying in FETCH/MEM means another stalled cycle; any move clears
            if ((r_state == S_FETCH || r_state == S_MEM) && w_next == r_state)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
        end
    end

    assign bus.IR          = r_ir;
    assign bus.Step        = r_step;
    assign bus.Mem_re      = w_mem_re;
    assign bus.Mem_we      = w_mem_we;
    assign bus.IR_load     = w_ir_load;
    assign bus.PC_load     = w_pc_load;
    assign bus.PC_sel      = w_pc_sel;
    assign bus.ALU_op      = w_alu_op;
    assign bus.ALU_src_imm = w_alu_imm;
    assign bus.PSW_we      = w_psw_we;
    assign bus.RF_we       = w_rf_we;
    assign bus.WB_sel      = w_wb_sel;
    assign bus.Out_valid   = w_out_valid;
    assign bus.Done        = w_done;
    assign bus.Halted      = w_halted;
    assign bus.Illegal     = w_illegal;
    assign bus.Fault       = w_fault;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench: each cycle's expected control word is queued as the stimulus
// for that cycle is applied, and popped/compared on the falling edge.
// Control word: {Mem_re,Mem_we,IR_load,PC_load,PC_sel,ALU_op,ALU_src_imm,
//                PSW_we,RF_we,WB_sel,Out_valid,Done,Halted,Illegal,Fault,Step}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    typedef logic [20:0] cw_t;
    typedef struct {
        string tag;
        cw_t   w;
    } exp_t;

    localparam cw_t MRE      = 21'h100000;
    localparam cw_t MWE      = 21'h080000;
    localparam cw_t IRL      = 21'h040000;
    localparam cw_t PCL      = 21'h020000;
    localparam cw_t PCS_DISP = 21'h008000;
    localparam cw_t PCS_REG  = 21'h010000;
    localparam cw_t PCS_IMM  = 21'h018000;
    localparam cw_t ALU_SUB  = 21'h004000;
    localparam cw_t ALU_SB   = 21'h006000;
    localparam cw_t IMM      = 21'h001000;
    localparam cw_t PSW      = 21'h000800;
    localparam cw_t RFW      = 21'h000400;
    localparam cw_t WB_MEM   = 21'h000100;
    localparam cw_t WB_IMM   = 21'h000200;
    localparam cw_t WB_PC    = 21'h000300;
    localparam cw_t OUTV     = 21'h000080;
    localparam cw_t DONE     = 21'h000040;
    localparam cw_t HALT     = 21'h000020;
    localparam cw_t ILL      = 21'h000010;
    localparam cw_t FLT      = 21'h000008;

    logic clk = 1'b0;
    logic Rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    multicycle_ctrl_if #(.INS_W(16), .CNT_W(3)) bus();

    multicycle_ctrl #(.INS_W(16), .CNT_W(3), .WAIT_MAX(15)) dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    cw_t obs;
    assign obs = {bus.Mem_re, bus.Mem_we, bus.IR_load, bus.PC_load, bus.PC_sel,
                  bus.ALU_op, bus.ALU_src_imm, bus.PSW_we, bus.RF_we, bus.WB_sel,
                  bus.Out_valid, bus.Done, bus.Halted, bus.Illegal, bus.Fault,
                  bus.Step};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            assert (obs === e.w) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.w);
            end
        end
    end

    function automatic cw_t st(input int s);
        return cw_t'((s > 7) ? 7 : s);
    endfunction

    task automatic step(input logic [15:0] ins, input logic rdy, input logic [2:0] psw,
                        input logic go, input string tag, input cw_t w);
        exp_t e;
        bus.Ins       = ins;
        bus.Mem_ready = rdy;
        bus.PSW_NZC   = psw;
        bus.Go        = go;
        e.tag = tag;
        e.w   = w;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input logic [15:0] ins, input logic [2:0] psw, input string tag);
        step(ins, 1'b1, psw, 1'b0, {tag, "_fetch"},  MRE | IRL | st(0));
        step(ins, 1'b1, psw, 1'b0, {tag, "_decode"}, PCL | st(1));
    endtask

    task automatic chk_ir(input logic [15:0] exp_ir, input string tag);
        n_tests++;
        assert (bus.IR === exp_ir) else begin
            n_fail++;
            $error("FAIL %s: observed IR %h expected %h", tag, bus.IR, exp_ir);
        end
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        @(posedge clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n         = 1'b0;
        bus.Ins       = '0;
        bus.Mem_ready = 1'b0;
        bus.PSW_NZC   = 3'b000;
        bus.Go        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Rst_n = 1'b1;
        chk_ir(16'h0000, "reset_ir");

        // ADD then SBB: four-cycle ALU path
        fetch_dec(16'h0000, 3'b000, "add");
        step(16'h0000, 1'b1, 3'b000, 1'b0, "add_exec", PSW | st(2));
        step(16'h0000, 1'b1, 3'b000, 1'b0, "add_wb",   RFW | DONE | st(3));
        fetch_dec(16'h0003, 3'b000, "sbb");
        step(16'h0003, 1'b1, 3'b000, 1'b0, "sbb_exec", ALU_SB | PSW | st(2));
        step(16'h0003, 1'b1, 3'b000, 1'b0, "sbb_wb",   RFW | DONE | st(3));

        // LDRri with three wait cycles in MEM
        fetch_dec(16'h1800, 3'b000, "ldr");
        chk_ir(16'h1800, "ldr_ir");
        step(16'h1800, 1'b0, 3'b000, 1'b0, "ldr_exec", IMM | st(2));
        for (int k = 3; k < 6; k++)
            step(16'h1800, 1'b0, 3'b000, 1'b0, "ldr_wait", MRE | st(k));
        step(16'h1800, 1'b1, 3'b000, 1'b0, "ldr_rdy", MRE | st(6));
        step(16'h1800, 1'b1, 3'b000, 1'b0, "ldr_wb",  RFW | WB_MEM | DONE | st(7));

        // STRrr with five waits: Step saturates at 7
        fetch_dec(16'h3000, 3'b000, "str");
        step(16'h3000, 1'b0, 3'b000, 1'b0, "str_exec", st(2));
        for (int k = 3; k < 8; k++)
            step(16'h3000, 1'b0, 3'b000, 1'b0, "str_wait", MWE | st(k));
        step(16'h3000, 1'b1, 3'b000, 1'b0, "str_rdy_sat", MWE | DONE | st(8));

        // Conditional branches
        fetch_dec(16'hC100, 3'b010, "beq_t");
        step(16'hC100, 1'b1, 3'b010, 1'b0, "beq_taken", PCL | PCS_DISP | DONE | st(2));
        fetch_dec(16'hC100, 3'b000, "beq_n");
        step(16'hC100, 1'b1, 3'b000, 1'b0, "beq_not",   DONE | st(2));
        fetch_dec(16'hC400, 3'b100, "bmi");
        step(16'hC400, 1'b1, 3'b100, 1'b0, "bmi_taken", PCL | PCS_DISP | DONE | st(2));
        fetch_dec(16'hC500, 3'b100, "bpl");
        step(16'hC500, 1'b1, 3'b100, 1'b0, "bpl_not",   DONE | st(2));
        fetch_dec(16'hC700, 3'b111, "bcc7");
        step(16'hC700, 1'b1, 3'b111, 1'b0, "bcc7_ill",  ILL | DONE | st(2));

        // Jumps / link
        fetch_dec(16'hC800, 3'b000, "bal");
        step(16'hC800, 1'b1, 3'b000, 1'b0, "bal_exec", PCL | PCS_DISP | st(2));
        step(16'hC800, 1'b1, 3'b000, 1'b0, "bal_wb",   RFW | WB_PC | DONE | st(3));
        fetch_dec(16'h9800, 3'b000, "jr");
        step(16'h9800, 1'b1, 3'b000, 1'b0, "jr_exec",  PCL | PCS_REG | DONE | st(2));
        fetch_dec(16'h8800, 3'b000, "jalrl");
        step(16'h8800, 1'b1, 3'b000, 1'b0, "jalrl_exec", PCL | PCS_IMM | st(2));
        step(16'h8800, 1'b1, 3'b000, 1'b0, "jalrl_wb",   RFW | WB_PC | DONE | st(3));

        // CMP, ADDI, MOV, OutR
        fetch_dec(16'h3001, 3'b000, "cmp");
        step(16'h3001, 1'b1, 3'b000, 1'b0, "cmp_exec",  ALU_SUB | PSW | DONE | st(2));
        fetch_dec(16'h3800, 3'b000, "addi");
        step(16'h3800, 1'b1, 3'b000, 1'b0, "addi_exec", IMM | PSW | st(2));
        step(16'h3800, 1'b1, 3'b000, 1'b0, "addi_wb",   RFW | DONE | st(3));
        fetch_dec(16'h5800, 3'b000, "mov");
        step(16'h5800, 1'b1, 3'b000, 1'b0, "mov_wb",    RFW | WB_IMM | DONE | st(2));
        fetch_dec(16'hE000, 3'b000, "outr");
        step(16'hE000, 1'b1, 3'b000, 1'b0, "outr_exec", OUTV | DONE | st(2));

        // Illegal opcodes trap in DECODE and return straight to FETCH
        step(16'hF800, 1'b1, 3'b000, 1'b0, "ill_fetch",  MRE | IRL | st(0));
        step(16'hF800, 1'b1, 3'b000, 1'b0, "ill_decode", PCL | ILL | DONE | st(1));
        step(16'h2001, 1'b1, 3'b000, 1'b0, "ill2_fetch",  MRE | IRL | st(0));
        step(16'h2001, 1'b1, 3'b000, 1'b0, "ill2_decode", PCL | ILL | DONE | st(1));

        // HLT: Done only on entry, Halted held, Go resumes
        fetch_dec(16'hE001, 3'b000, "hlt");
        step(16'hE001, 1'b1, 3'b000, 1'b0, "hlt_entry", HALT | DONE | st(2));
        for (int k = 0; k < 10; k++)
            step(16'hE001, 1'b1, 3'b000, 1'b0, "hlt_hold", HALT | st(k));
        step(16'hE001, 1'b1, 3'b000, 1'b1, "hlt_go", HALT | st(10));

        // Resume into FETCH with memory stuck: timeout after 15 cycles
        for (int k = 0; k < 15; k++)
            step(16'h0000, 1'b0, 3'b000, 1'b0, "to_wait", MRE | st(k));
        step(16'h0000, 1'b1, 3'b000, 1'b0, "fault",        FLT | st(7));
        step(16'h0000, 1'b1, 3'b000, 1'b1, "fault_sticky", FLT | st(7));

        // Reset clears FAULT
        do_reset();
        fetch_dec(16'h0000, 3'b000, "post_fault");
        step(16'h0000, 1'b1, 3'b000, 1'b0, "post_fault_exec", PSW | st(2));
        step(16'h0000, 1'b1, 3'b000, 1'b0, "post_fault_wb",   RFW | DONE | st(3));

        // Reset in the middle of a MEM wait
        fetch_dec(16'h1800, 3'b000, "rstmem");
        step(16'h1800, 1'b0, 3'b000, 1'b0, "rstmem_exec", IMM | st(2));
        step(16'h1800, 1'b0, 3'b000, 1'b0, "rstmem_w0",   MRE | st(3));
        step(16'h1800, 1'b0, 3'b000, 1'b0, "rstmem_w1",   MRE | st(4));
        do_reset();
        chk_ir(16'h0000, "rstmem_ir");
        step(16'h1800, 1'b1, 3'b000, 1'b0, "rstmem_fetch", MRE | IRL | st(0));

        n_tests++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised next-generation control unit for the multicycle 16-bit RISC core.
- Replaces the combinational instruction decoder plus external step counter with one sequencer: an internal FSM, an instruction register and a step counter.
- Adds a memory ready/wait handshake with timeout, full N/Z/C branch conditions (adds BMI/BPL), an illegal-opcode trap and halt/resume.
- Sits between instruction/data memory, the register file, the ALU and the PC/PSW registers.

Parameters:
INS_W, 16, instruction width; opcode = Ins[INS_W-1 -: 5], cond = Ins[INS_W-6 -: 3], funct = Ins[1:0]
CNT_W, 3, width of Step counter
WAIT_MAX, 15, max wait cycles for Mem_ready before Fault (0 = no timeout)

Ports:
clk  in  1  clock
Rst_n  in  1  synchronous active-low reset
Ins  in  INS_W  instruction bus from memory
Mem_ready  in  1  memory access complete this cycle
PSW_NZC  in  3  {N,Z,C} flags
Go  in  1  resume from HALT
IR  out  INS_W  latched instruction
Step  out  CNT_W  cycle index within current instruction
Mem_re  out  1  memory read request (fetch or load)
Mem_we  out  1  memory write request
IR_load  out  1  IR captures Ins
PC_load  out  1  PC update strobe
PC_sel  out  2  00 PC+1, 01 PC+disp, 10 register, 11 immediate
ALU_op  out  2  00 add, 01 add-carry, 10 sub, 11 sub-borrow
ALU_src_imm  out  1  ALU B operand = immediate
PSW_we  out  1  flag update
RF_we  out  1  register file write
WB_sel  out  2  00 ALU, 01 memory, 10 immediate/MOV, 11 PC link
Out_valid  out  1  OutR strobe
Done  out  1  last cycle of instruction
Halted  out  1  in HALT
Illegal  out  1  undefined opcode pulse
Fault  out  1  sticky memory timeout

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- Rst_n=0 at a clk edge: state=FETCH, IR=0, Step=0, Fault=0. All strobes and Halted are 0 from the next cycle. Reset is honoured mid-instruction and mid-wait, and overrides everything else.
- FETCH: Mem_re=1; hold until Mem_ready=1. In that cycle IR_load=1, IR<=Ins, go to DECODE.
- DECODE: PC_load=1, PC_sel=00. Next state by class:
  - ALU/CMP/ADDI/SUBI/LDR/STR/Bcc/BAL/JMP/JALrl/JALrr/JR/OutR -> EXEC
  - LHI/LLI/MOV -> WB
  - HLT -> HALT
  - undefined -> FETCH with Illegal=1 and Done=1
- Opcodes:
  - 00000: ADD/ADC/SUB/SBB, funct 00..11 maps to ALU_op
  - 00001: LHI; 00010: LLI; 00011: LDRri; 00100 f00: LDRrr
  - 00101: STRri; 00110 f00: STRrr; 00110 f01: CMP
  - 00111: ADDI; 01000: SUBI; 01011: MOV
  - 11000: Bcc; 11001: BAL
  - 10000: JMP; 10001: JALrl; 10010: JALrr; 10011: JR
  - 11100 f00: OutR; 11100 f01: HLT
  - Everything else is undefined.
- EXEC:
  - ALU/ADDI/SUBI: ALU_op set, PSW_we=1, -> WB. CMP: ALU_op=10, PSW_we=1, Done=1, -> FETCH. ADDI/SUBI also set ALU_src_imm=1 with ALU_op 00/10.
  - LDR/STR: ALU_op=00 address add (ALU_src_imm=1 for ri) -> MEM.
  - Bcc, cond 000 NE(!Z), 001 EQ(Z), 010 CS(C), 011 CC(!C), 100 MI(N), 101 PL(!N), 110 AL, 111 undefined (Illegal=1, not taken). If taken: PC_load=1, PC_sel=01. Done=1, -> FETCH.
  - BAL: unconditional PC_sel=01 -> WB (link). JMP: PC_sel=11. JR: PC_sel=10. Both Done=1 -> FETCH.
  - JALrl: PC_sel=11 -> WB. JALrr: PC_sel=10 -> WB.
  - OutR: Out_valid=1, Done=1 -> FETCH.
- MEM: LDR asserts Mem_re, STR asserts Mem_we; hold until Mem_ready. Then LDR -> WB; STR gives Done=1 -> FETCH.
- WB: RF_we=1, Done=1 -> FETCH. WB_sel = 00 for ALU, 01 for LDR, 10 for LHI/LLI/MOV, 11 for BAL/JAL.
- Timeout: wait counter clears on entering FETCH/MEM. If WAIT_MAX>0 and WAIT_MAX cycles pass without Mem_ready, go to FAULT: Fault=1 sticky, all strobes 0, exit only by reset.
- HALT: Halted=1, Done=1 on the entry cycle only. Go=1 -> FETCH next cycle.
- Step: 0 in the first FETCH cycle, +1 each cycle, saturates at 2^CNT_W-1, returns to 0 the cycle after Done.
- PSW_NZC is sampled combinationally in EXEC.

Test Plan:
- Reset then ADD (0x0000, Mem_ready=1 always) -> FETCH,DECODE,EXEC,WB over Step 0..3; RF_we=1, WB_sel=00 at Step 3, Done=1 at Step 3.
- LDRri 0x1800, Mem_ready low 3 cycles in MEM -> Mem_re held 3 cycles, then WB_sel=01, RF_we=1; 8 cycles total; Step saturates at 7.
- BEQ 0xC100 with PSW_NZC=010 -> PC_load=1, PC_sel=01 in EXEC; with 000 -> no PC_load in EXEC. BMI 0xC400 with N=1 -> taken.
- Opcode 11111 -> Illegal=1 and Done=1 in DECODE; next cycle FETCH.
- HLT 0xE001 -> Halted stays 1 for 10 cycles; Go pulse -> FETCH, Mem_re=1 next cycle.
- Mem_ready stuck 0 in FETCH with WAIT_MAX=15 -> Fault=1 after 15 cycles; Rst_n=0 for one edge -> Fault=0, FETCH; also assert Rst_n=0 mid-MEM -> FETCH, Step=0.
